link_vc_arbiter: RTL and testbench

- Shares one inter-chiplet link lane between two virtual channels: VC0 carries master requests, VC1 carries slave responses.
- Each VC presents flits from its tx FSM. The arbiter grants whole packets round-robin and tags each flit with its VC id.
- Per-VC credit counters mirror the receive-FIFO space at the far end. A flit is sent only when its VC holds a credit, so the link never needs backpressure.

---
 rtl/link_vc_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_link_vc_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/link_vc_arbiter.sv
// Two-VC link arbiter: whole-packet round-robin grant onto one lane, with
// per-VC credit counters that mirror the far-end receive FIFO space.
module link_vc_arbiter #(
   parameter int DATA_LINE_WIDTH = 40,
   parameter int FIFO_DEPTH      = 32,
   parameter int LOG2_FIFO_DEPTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_LINE_WIDTH-1:0] i_vc0_flit,
   input  logic                       i_vc0_valid,
   input  logic                       i_vc0_last,
   output logic                       o_vc0_ready,
   input  logic [DATA_LINE_WIDTH-1:0] i_vc1_flit,
   input  logic                       i_vc1_valid,
   input  logic                       i_vc1_last,
   output logic                       o_vc1_ready,
   input  logic                       i_credit_return_vc0,
   input  logic                       i_credit_return_vc1,
   output logic [DATA_LINE_WIDTH-1:0] o_link_flit,
   output logic                       o_link_vc,
   output logic                       o_link_valid,
   output logic [LOG2_FIFO_DEPTH:0]   o_credits_vc0,
   output logic [LOG2_FIFO_DEPTH:0]   o_credits_vc1,
   output logic                       o_credit_err
);

   localparam int CW = LOG2_FIFO_DEPTH + 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t                     state_q;
   logic                       last_vc_q;
   logic [CW-1:0]              cred0_q, cred1_q;
   logic [CW-1:0]              cred0_d, cred1_d;
   logic                       err_d;
   logic [DATA_LINE_WIDTH-1:0] link_flit_q;
   logic                       link_vc_q;
   logic                       link_valid_q;
   logic                       err_q;

   logic elig0_s, elig1_s;
   logic ready0_s, ready1_s;
   logic xfer0_s, xfer1_s;

   // Transfer consumes a credit, return adds one; a return at full is held at full.
   function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                 input logic          xfer,
                                                 input logic          ret);
      logic [CW-1:0] nxt;
      if (xfer && !ret) begin
         nxt = cur - CW'(1);
      end else if (ret && !xfer) begin
         nxt = (cur == CRED_MAX) ? cur : cur + CW'(1);
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

   function automatic logic credit_overflow(input logic [CW-1:0] cur,
                                            input logic          xfer,
                                            input logic          ret);
      return ret && !xfer && (cur == CRED_MAX);
   endfunction

   assign elig0_s = i_vc0_valid && (cred0_q != '0);
   assign elig1_s = i_vc1_valid && (cred1_q != '0);

   // Grant: round-robin in IDLE, held by the packet owner while BUSY.
   always_comb begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (elig0_s && elig1_s) begin
               ready0_s = last_vc_q;
               ready1_s = !last_vc_q;
            end else begin
               ready0_s = elig0_s;
               ready1_s = elig1_s;
            end
         end
         BUSY0: begin
            ready0_s = (cred0_q != '0);
            ready1_s = 1'b0;
         end
         BUSY1: begin
            ready0_s = 1'b0;
            ready1_s = (cred1_q != '0);
         end
         default: begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
         end
      endcase
   end

   assign xfer0_s = i_vc0_valid && ready0_s;
   assign xfer1_s = i_vc1_valid && ready1_s;

   // Credit next-state and overflow detection.
   always_comb begin
      cred0_d = credit_next(cred0_q, xfer0_s, i_credit_return_vc0);
      cred1_d = credit_next(cred1_q, xfer1_s, i_credit_return_vc1);
      err_d   = err_q
              | credit_overflow(cred0_q, xfer0_s, i_credit_return_vc0)
              | credit_overflow(cred1_q, xfer1_s, i_credit_return_vc1);
   end

   // Packet FSM and round-robin history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_vc_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer0_s) begin
                  if (i_vc0_last) begin
                     last_vc_q <= 1'b0;
                  end else begin
                     state_q <= BUSY0;
                  end
               end else if (xfer1_s) begin
                  if (i_vc1_last) begin
                     last_vc_q <= 1'b1;
                  end else begin
                     state_q <= BUSY1;
                  end
               end
            end
            BUSY0: begin
               if (xfer0_s && i_vc0_last) begin
                  state_q   <= IDLE;
                  last_vc_q <= 1'b0;
               end
            end
            BUSY1: begin
               if (xfer1_s && i_vc1_last) begin
                  state_q   <= IDLE;
                  last_vc_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Link register: flit and VC id hold their value when nothing is sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         link_valid_q <= 1'b0;
         link_flit_q  <= '0;
         link_vc_q    <= 1'b0;
      end else if (xfer0_s) begin
         link_valid_q <= 1'b1;
         link_flit_q  <= i_vc0_flit;
         link_vc_q    <= 1'b0;
      end else if (xfer1_s) begin
         link_valid_q <= 1'b1;
         link_flit_q  <= i_vc1_flit;
         link_vc_q    <= 1'b1;
      end else begin
         link_valid_q <= 1'b0;
      end
   end

   // Credit counters and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cred0_q <= CRED_MAX;
         cred1_q <= CRED_MAX;
         err_q   <= 1'b0;
      end else begin
         cred0_q <= cred0_d;
         cred1_q <= cred1_d;
         err_q   <= err_d;
      end
   end

   assign o_vc0_ready   = ready0_s;
   assign o_vc1_ready   = ready1_s;
   assign o_link_flit   = link_flit_q;
   assign o_link_vc     = link_vc_q;
   assign o_link_valid  = link_valid_q;
   assign o_credits_vc0 = cred0_q;
   assign o_credits_vc1 = cred1_q;
   assign o_credit_err  = err_q;

endmodule

// File: tb/tb_link_vc_arbiter.sv
// Directed bench for link_vc_arbiter with hand-computed expectations.
module tb_link_vc_arbiter;

   logic        clk;
   logic        rst;
   logic [39:0] vc0_flit, vc1_flit;
   logic        vc0_valid, vc0_last, vc1_valid, vc1_last;
   logic        vc0_ready, vc1_ready;
   logic        ret0, ret1;
   logic [39:0] link_flit;
   logic        link_vc, link_valid;
   logic [5:0]  cred0, cred1;
   logic        credit_err;

   int checks = 0;
   int errors = 0;

   link_vc_arbiter #(
      .DATA_LINE_WIDTH(40),
      .FIFO_DEPTH     (32),
      .LOG2_FIFO_DEPTH(5)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_vc0_flit         (vc0_flit),
      .i_vc0_valid        (vc0_valid),
      .i_vc0_last         (vc0_last),
      .o_vc0_ready        (vc0_ready),
      .i_vc1_flit         (vc1_flit),
      .i_vc1_valid        (vc1_valid),
      .i_vc1_last         (vc1_last),
      .o_vc1_ready        (vc1_ready),
      .i_credit_return_vc0(ret0),
      .i_credit_return_vc1(ret1),
      .o_link_flit        (link_flit),
      .o_link_vc          (link_vc),
      .o_link_valid       (link_valid),
      .o_credits_vc0      (cred0),
      .o_credits_vc1      (cred1),
      .o_credit_err       (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      vc0_flit = 40'd0; vc0_valid = 1'b0; vc0_last = 1'b0;
      vc1_flit = 40'd0; vc1_valid = 1'b0; vc1_last = 1'b0;
      ret0 = 1'b0; ret1 = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      #12;
      // Reset state
      check_val("rst_valid", 64'(link_valid), 64'd0);
      check_val("rst_flit", 64'(link_flit), 64'd0);
      check_val("rst_vc", 64'(link_vc), 64'd0);
      check_val("rst_cred0", 64'(cred0), 64'd32);
      check_val("rst_cred1", 64'(cred1), 64'd32);
      check_val("rst_err", 64'(credit_err), 64'd0);
      check_val("rst_rdy0", 64'(vc0_ready), 64'd0);
      check_val("rst_rdy1", 64'(vc1_ready), 64'd0);

      // VC0 3-flit packet while VC1 waits
      do_reset();
      vc1_valid = 1'b1; vc1_last = 1'b1; vc1_flit = 40'h0B0B;
      for (int i = 0; i < 3; i++) begin
         vc0_valid = 1'b1; vc0_last = (i == 2); vc0_flit = 40'hA0 + 40'(i);
         #1;
         check_val("pkt_rdy0", 64'(vc0_ready), 64'd1);
         check_val("pkt_rdy1", 64'(vc1_ready), 64'd0);
         if (i > 0) check_val("pkt_link_flit", 64'(link_flit), 64'hA0 + 64'(i - 1));
         tick();
         check_val("pkt_link_valid", 64'(link_valid), 64'd1);
         check_val("pkt_link_vc", 64'(link_vc), 64'd0);
      end
      vc0_valid = 1'b0; vc0_last = 1'b0;
      #1;
      check_val("pkt_last_flit", 64'(link_flit), 64'hA2);
      check_val("pkt_cred0", 64'(cred0), 64'd29);
      check_val("pkt_rdy1_after", 64'(vc1_ready), 64'd1);
      tick();
      check_val("pkt_vc1_link_vc", 64'(link_vc), 64'd1);
      check_val("pkt_vc1_flit", 64'(link_flit), 64'h0B0B);

      // Round-robin with continuous single-flit packets
      do_reset();
      for (int i = 0; i < 8; i++) begin
         vc0_valid = 1'b1; vc0_last = 1'b1; vc0_flit = 40'd100 + 40'(i);
         vc1_valid = 1'b1; vc1_last = 1'b1; vc1_flit = 40'd200 + 40'(i);
         #1;
         check_val("rr_rdy0", 64'(vc0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
         check_val("rr_rdy1", 64'(vc1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
         tick();
         check_val("rr_valid", 64'(link_valid), 64'd1);
         check_val("rr_vc", 64'(link_vc), 64'(i % 2));
         check_val("rr_flit", 64'(link_flit), (i % 2 == 0) ? 64'd100 + 64'(i) : 64'd200 + 64'(i));
      end
      check_val("rr_cred0", 64'(cred0), 64'd28);
      check_val("rr_cred1", 64'(cred1), 64'd28);

      // VC1 drains all credits, then one return
      do_reset();
      vc1_valid = 1'b1; vc1_last = 1'b1; vc1_flit = 40'h1234;
      repeat (32) tick();
      check_val("drain_cred1", 64'(cred1), 64'd0);
      check_val("drain_rdy1", 64'(vc1_ready), 64'd0);
      check_val("drain_valid", 64'(link_valid), 64'd1);
      ret1 = 1'b1;
      tick();
      ret1 = 1'b0;
      #1;
      check_val("ret_cred1", 64'(cred1), 64'd1);
      check_val("ret_rdy1", 64'(vc1_ready), 64'd1);
      check_val("ret_blocked_valid", 64'(link_valid), 64'd0);
      tick();
      check_val("ret_send_valid", 64'(link_valid), 64'd1);
      check_val("ret_send_vc", 64'(link_vc), 64'd1);
      check_val("ret_cred1_zero", 64'(cred1), 64'd0);

      // VC0 starves mid-packet with the grant held
      do_reset();
      vc1_valid = 1'b1; vc1_last = 1'b1; vc1_flit = 40'h77;
      vc0_valid = 1'b1; vc0_last = 1'b0; vc0_flit = 40'h55;
      repeat (32) tick();
      check_val("stall_cred0", 64'(cred0), 64'd0);
      tick();
      check_val("stall_rdy0", 64'(vc0_ready), 64'd0);
      check_val("stall_rdy1", 64'(vc1_ready), 64'd0);
      check_val("stall_cred1", 64'(cred1), 64'd32);
      vc0_valid = 1'b0; ret0 = 1'b1;
      tick(); tick();
      ret0 = 1'b0;
      #1;
      check_val("stall_cred0_ret", 64'(cred0), 64'd2);
      check_val("stall_rdy0_novalid", 64'(vc0_ready), 64'd1);
      check_val("stall_rdy1_held", 64'(vc1_ready), 64'd0);
      vc0_valid = 1'b1; vc0_last = 1'b0; vc0_flit = 40'h56;
      tick();
      vc0_last = 1'b1; vc0_flit = 40'h57;
      tick();
      check_val("stall_end_flit", 64'(link_flit), 64'h57);
      vc0_valid = 1'b0; vc0_last = 1'b0;
      #1;
      check_val("stall_cred0_end", 64'(cred0), 64'd0);
      check_val("stall_rdy1_free", 64'(vc1_ready), 64'd1);
      tick();
      check_val("stall_vc1_vc", 64'(link_vc), 64'd1);

      // Credit overflow and simultaneous xfer + return
      do_reset();
      ret0 = 1'b1;
      tick();
      ret0 = 1'b0;
      check_val("ovf_cred0", 64'(cred0), 64'd32);
      check_val("ovf_err", 64'(credit_err), 64'd1);
      vc1_valid = 1'b1; vc1_last = 1'b1; vc1_flit = 40'h99;
      repeat (12) tick();
      check_val("sim_cred1_pre", 64'(cred1), 64'd20);
      ret1 = 1'b1;
      #1;
      check_val("sim_rdy1", 64'(vc1_ready), 64'd1);
      tick();
      ret1 = 1'b0; vc1_valid = 1'b0;
      check_val("sim_cred1", 64'(cred1), 64'd20);
      check_val("sim_valid", 64'(link_valid), 64'd1);
      check_val("ovf_err_sticky", 64'(credit_err), 64'd1);

      // Asynchronous reset in BUSY1
      do_reset();
      vc1_valid = 1'b1; vc1_last = 1'b0; vc1_flit = 40'hCC;
      tick(); tick();
      check_val("busy1_cred1", 64'(cred1), 64'd30);
      #2;
      rst = 1'b0;
      #1;
      check_val("arst_valid", 64'(link_valid), 64'd0);
      check_val("arst_flit", 64'(link_flit), 64'd0);
      check_val("arst_cred1", 64'(cred1), 64'd32);
      vc1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      vc0_valid = 1'b1; vc0_last = 1'b1; vc0_flit = 40'hD0;
      vc1_valid = 1'b1; vc1_last = 1'b1; vc1_flit = 40'hD1;
      #1;
      check_val("arst_tie_rdy0", 64'(vc0_ready), 64'd1);
      check_val("arst_tie_rdy1", 64'(vc1_ready), 64'd0);
      check_val("arst_cred0", 64'(cred0), 64'd32);
      tick();
      check_val("arst_tie_vc", 64'(link_vc), 64'd0);
      check_val("arst_tie_flit", 64'(link_flit), 64'hD0);
      clear_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
